debounce_ctrl: RTL

Debounce sequencer that sits between the edge detector and the button event consumers, and paces itself on the count-enable strobe. It tracks the raw synchronized button level through a four-state machine, counting enable strobes of stable level before declaring a press or release. It emits single-cycle press, release and long-press events, plus a restart request that re-phases the enable generator on every accepted edge.

---
 rtl/pipeline_types_pkg.sv | 16 +
 rtl/debounce_ctrl.sv | 145 ++++++++++++++
 2 files changed

// File: rtl/pipeline_types_pkg.sv
// Types shared across the button input pipeline: edge pulses and debounce sequencer states.
package pipeline_types;

  typedef struct packed {
    logic rise;
    logic fall;
  } edges_t;

  typedef enum logic [1:0] {
    IDLE,
    ARM_PRESS,
    PRESSED,
    ARM_RELEASE
  } debounce_state_t;

endpackage

// File: rtl/debounce_ctrl.sv
// Debounce sequencer: counts enable strobes of stable level before accepting a press or release,
// and emits registered press/release/long-press/restart pulses.
module debounce_ctrl
  import pipeline_types::*;
#(
  parameter int unsigned STABLE_TICKS = 4,
  parameter int unsigned LONG_TICKS   = 50
) (
  input  logic   i_clk,
  input  logic   i_reset,
  input  edges_t i_edges,
  input  logic   i_level,
  input  logic   i_count_enable,
  output logic   o_level,
  output logic   o_press,
  output logic   o_release,
  output logic   o_long_press,
  output logic   o_restart
);

  localparam int unsigned CntW = $clog2(LONG_TICKS + 1);
  localparam logic [CntW-1:0] StableLast = CntW'(STABLE_TICKS - 1);
  localparam logic [CntW-1:0] LongLast   = CntW'(LONG_TICKS - 1);

  if (STABLE_TICKS == 0 || LONG_TICKS <= STABLE_TICKS) begin : g_bad_params
    $error("debounce_ctrl: need STABLE_TICKS >= 1 and LONG_TICKS > STABLE_TICKS");
  end

  debounce_state_t state_q, state_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic            long_q, long_d;
  logic            level_q, level_d;
  logic            press_q, press_d;
  logic            release_q, release_d;
  logic            long_press_q, long_press_d;
  logic            restart_q, restart_d;

  logic rise_only, fall_only, any_edge;

  assign rise_only = i_edges.rise & ~i_edges.fall;
  assign fall_only = i_edges.fall & ~i_edges.rise;
  // Any decoded edge pre-empts a strobe in the same cycle, even one the state ignores.
  assign any_edge  = rise_only | fall_only;

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    long_d       = long_q;
    level_d      = level_q;
    press_d      = 1'b0;
    release_d    = 1'b0;
    long_press_d = 1'b0;
    restart_d    = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (rise_only) begin
          state_d   = ARM_PRESS;
          cnt_d     = '0;
          restart_d = 1'b1;
        end
      end
      ARM_PRESS: begin
        if (fall_only) begin
          state_d   = IDLE;
          cnt_d     = '0;
          restart_d = 1'b1;
        end else if (!any_edge && i_count_enable && i_level) begin
          if (cnt_q == StableLast) begin
            state_d = PRESSED;
            cnt_d   = '0;
            long_d  = 1'b0;
            level_d = 1'b1;
            press_d = 1'b1;
          end else begin
            cnt_d = cnt_q + CntW'(1);
          end
        end
      end
      PRESSED: begin
        if (fall_only) begin
          state_d   = ARM_RELEASE;
          cnt_d     = '0;
          restart_d = 1'b1;
        end else if (!any_edge && i_count_enable && i_level) begin
          if (cnt_q == LongLast) begin
            if (!long_q) begin
              long_d       = 1'b1;
              long_press_d = 1'b1;
            end
          end else begin
            cnt_d = cnt_q + CntW'(1);
          end
        end
      end
      ARM_RELEASE: begin
        // Long flag survives a release glitch so a held button yields one long press.
        if (rise_only) begin
          state_d   = PRESSED;
          cnt_d     = '0;
          restart_d = 1'b1;
        end else if (!any_edge && i_count_enable && !i_level) begin
          if (cnt_q == StableLast) begin
            state_d   = IDLE;
            cnt_d     = '0;
            level_d   = 1'b0;
            release_d = 1'b1;
          end else begin
            cnt_d = cnt_q + CntW'(1);
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      long_q       <= 1'b0;
      level_q      <= 1'b0;
      press_q      <= 1'b0;
      release_q    <= 1'b0;
      long_press_q <= 1'b0;
      restart_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      long_q       <= long_d;
      level_q      <= level_d;
      press_q      <= press_d;
      release_q    <= release_d;
      long_press_q <= long_press_d;
      restart_q    <= restart_d;
    end
  end

  assign o_level      = level_q;
  assign o_press      = press_q;
  assign o_release    = release_q;
  assign o_long_press = long_press_q;
  assign o_restart    = restart_q;

endmodule
